// File: rtl/score_renderer.sv
// Score renderer: converts a binary score to BCD, sweeps the digit sprites
// through the loadscore ROM and turns returned pixels into VGA plot writes.
module score_renderer #(
  parameter int NUM_DIGITS    = 4,
  parameter int DIGIT_W       = 16,
  parameter int DIGIT_H       = 32,
  parameter int BLANK_LEADING = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] score,
  input  logic [7:0]  x_origin,
  input  logic [6:0]  y_origin,
  output logic [4:0]  id,
  output logic [3:0]  i,
  output logic [6:0]  j,
  input  logic [14:0] colour_in,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CONVERT, DRAW, FLUSH, DONE} state_t;

  state_t      state, state_next;
  logic [13:0] bin_sr;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  conv_cnt;
  logic [1:0]  d_cnt;
  logic [4:0]  j_cnt;
  logic [3:0]  i_cnt;
  logic [7:0]  x_base;
  logic [6:0]  y_base;
  logic [2:0]  colour_hold;
  logic [13:0] score_sat;
  logic        last_addr;
  logic [3:0]  cur_digit;
  logic        leading_zero;
  logic [4:0]  digit_id;
  logic        unused_colour_bits;

  // The ROM word carries more bits than the 3-bit VGA colour needs.
  assign unused_colour_bits = ^colour_in[14:3];

  assign score_sat = (score > 14'd9999) ? 14'd9999 : score;
  assign last_addr = (d_cnt == 2'(NUM_DIGITS - 1)) &&
                     (j_cnt == 5'(DIGIT_H - 1)) &&
                     (i_cnt == 4'(DIGIT_W - 1));

  // Double-dabble correction: every BCD nibble of 5 or more gets 3 added before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 4; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
    end
  end

  // Select the digit for the current slot (slot 0 is the MSD) and decide whether it is a leading zero.
  always_comb begin
    cur_digit    = bcd[3:0];
    leading_zero = 1'b0;
    case (d_cnt)
      2'd0: begin
        cur_digit    = bcd[15:12];
        leading_zero = (bcd[15:12] == 4'd0);
      end
      2'd1: begin
        cur_digit    = bcd[11:8];
        leading_zero = (bcd[15:8] == 8'd0);
      end
      2'd2: begin
        cur_digit    = bcd[7:4];
        leading_zero = (bcd[15:4] == 12'd0);
      end
      default: begin
        cur_digit    = bcd[3:0];
        leading_zero = 1'b0;
      end
    endcase
    digit_id = ((BLANK_LEADING != 0) && leading_zero) ? 5'd10 : {1'b0, cur_digit};
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: convert for 14 shifts, draw every address, then flush the last pixel.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONVERT;
      CONVERT: if (conv_cnt == 4'd13) state_next = DRAW;
      DRAW:    if (last_addr) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch the request, run the BCD shifts, step the sprite counters and register pixel coordinates.
  always_ff @(posedge clock) begin
    if (reset) begin
      bin_sr      <= '0;
      bcd         <= '0;
      conv_cnt    <= '0;
      d_cnt       <= '0;
      j_cnt       <= '0;
      i_cnt       <= '0;
      x_base      <= '0;
      y_base      <= '0;
      x           <= '0;
      y           <= '0;
      colour_hold <= '0;
      plot        <= 1'b0;
    end else begin
      plot <= (state == DRAW);
      if (plot) colour_hold <= colour_in[2:0];
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr   <= score_sat;
            bcd      <= '0;
            conv_cnt <= '0;
            x_base   <= x_origin;
            y_base   <= y_origin;
          end
        end
        CONVERT: begin
          {bcd, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
          conv_cnt      <= conv_cnt + 4'd1;
        end
        DRAW: begin
          x <= x_base + 8'(d_cnt) * 8'(DIGIT_W) + 8'(i_cnt);
          y <= y_base + {2'b00, j_cnt};
          if (i_cnt == 4'(DIGIT_W - 1)) begin
            i_cnt <= '0;
            if (j_cnt == 5'(DIGIT_H - 1)) begin
              j_cnt <= '0;
              d_cnt <= d_cnt + 2'd1;
            end else begin
              j_cnt <= j_cnt + 5'd1;
            end
          end else begin
            i_cnt <= i_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: address only meaningful while drawing, status from state, colour passes through while plotting.
  always_comb begin
    busy   = (state == CONVERT) || (state == DRAW) || (state == FLUSH);
    done   = (state == DONE);
    id     = (state == DRAW) ? digit_id : 5'd0;
    i      = i_cnt;
    j      = {2'b00, j_cnt};
    colour = plot ? colour_in[2:0] : colour_hold;
  end

endmodule

// File: tb/tb_score_renderer.sv
// Testbench for score_renderer: two instances (normal and leading-zero blanking)
// checked every cycle against a cycle-count based reference model, plus literal checks.
module tb_score_renderer;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic [13:0] score;
  logic [7:0]  x_origin;
  logic [6:0]  y_origin;

  logic [1:0][4:0]  idv;
  logic [1:0][3:0]  iv;
  logic [1:0][6:0]  jv;
  logic [1:0][14:0] colv;
  logic [1:0][7:0]  xv;
  logic [1:0][6:0]  yv;
  logic [1:0][2:0]  cv;
  logic [1:0]       plotv, busyv, donev;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model state: cycle index since the accepting edge and held pixel values.
  bit m_active = 1'b0;
  int m_t = 0;
  int m_score = 0;
  int m_xo = 0, m_yo = 0;
  int m_lastx = 0, m_lasty = 0;
  int m_lastc[2] = '{0, 0};

  // Per-run observations used by the literal checks.
  int rec_plots[2], rec_firstx[2], rec_firsty[2], rec_lastx[2], rec_lasty[2], rec_done_t[2];
  int rec_ids[2][4];
  bit rec_abort_done;

  // Free-running clock.
  always #5 clock = ~clock;

  score_renderer #(.BLANK_LEADING(0)) dut_z (
    .clock(clock), .reset(reset), .start(start), .score(score),
    .x_origin(x_origin), .y_origin(y_origin),
    .id(idv[0]), .i(iv[0]), .j(jv[0]), .colour_in(colv[0]),
    .x(xv[0]), .y(yv[0]), .colour(cv[0]), .plot(plotv[0]),
    .busy(busyv[0]), .done(donev[0])
  );

  score_renderer #(.BLANK_LEADING(1)) dut_b (
    .clock(clock), .reset(reset), .start(start), .score(score),
    .x_origin(x_origin), .y_origin(y_origin),
    .id(idv[1]), .i(iv[1]), .j(jv[1]), .colour_in(colv[1]),
    .x(xv[1]), .y(yv[1]), .colour(cv[1]), .plot(plotv[1]),
    .busy(busyv[1]), .done(donev[1])
  );

  function automatic logic [14:0] rom_pixel(input int sid, input int ci, input int rj);
    return 15'((sid * 2531 + ci * 97 + rj * 13 + (ci ^ rj) * 7) ^ (sid << 5));
  endfunction

  // Sprite id expected for slot d (0 = MSD) of a saturated score.
  function automatic int exp_id(input int sat, input int d, input int blank);
    int place;
    place = (d == 0) ? 1000 : (d == 1) ? 100 : (d == 2) ? 10 : 1;
    if (blank != 0 && d < 3 && sat < place) return 10;
    return (sat / place) % 10;
  endfunction

  // Loadscore ROM model: one cycle of latency per instance.
  always @(posedge clock) begin
    colv[0] <= rom_pixel(int'(idv[0]), int'(iv[0]), int'(jv[0]));
    colv[1] <= rom_pixel(int'(idv[1]), int'(iv[1]), int'(jv[1]));
  end

  // Reference model advance on each active edge.
  always @(posedge clock) begin
    int k, d, ci, rj;
    if (reset) begin
      m_active = 1'b0;
      m_t = 0;
      m_lastx = 0;
      m_lasty = 0;
      m_lastc[0] = 0;
      m_lastc[1] = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_t = 1;
        m_score = (int'(score) > 9999) ? 9999 : int'(score);
        m_xo = int'(x_origin);
        m_yo = int'(y_origin);
      end
    end else begin
      m_t++;
      if (m_t > 2064) begin
        m_active = 1'b0;
        m_t = 0;
      end else if (m_t >= 16 && m_t <= 2063) begin
        k  = m_t - 16;
        d  = k / 512;
        rj = (k % 512) / 16;
        ci = k % 16;
        m_lastx = (m_xo + d * 16 + ci) % 256;
        m_lasty = (m_yo + rj) % 128;
        for (int u = 0; u < 2; u++) m_lastc[u] = int'(rom_pixel(exp_id(m_score, d, u), ci, rj)) & 7;
      end
    end
  end

  task automatic checkOutput(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d t=%0d: got %0d, expected %0d", name, u, m_t, act, exp);
    end
  endtask

  task automatic checkCycle(input int u);
    int k, d;
    checkOutput("busy", u, 32'(busyv[u]), 32'(m_active && m_t >= 1 && m_t <= 2063));
    checkOutput("done", u, 32'(donev[u]), 32'(m_active && m_t == 2064));
    checkOutput("plot", u, 32'(plotv[u]), 32'(m_active && m_t >= 16 && m_t <= 2063));
    if (m_active && m_t >= 15 && m_t <= 2062) begin
      k = m_t - 15;
      d = k / 512;
      checkOutput("id", u, 32'(idv[u]), 32'(exp_id(m_score, d, u)));
      checkOutput("j", u, 32'(jv[u]), 32'((k % 512) / 16));
      checkOutput("i", u, 32'(iv[u]), 32'(k % 16));
    end
    checkOutput("x", u, 32'(xv[u]), 32'(m_lastx));
    checkOutput("y", u, 32'(yv[u]), 32'(m_lasty));
    checkOutput("colour", u, 32'(cv[u]), 32'(m_lastc[u]));
  endtask

  // Per-cycle compare of both instances against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      checkCycle(0);
      checkCycle(1);
    end
  end

  task automatic applyStimulus(input int sc, input int xo, input int yo, input int ignore_at, input int abort_at);
    int t;
    for (int u = 0; u < 2; u++) begin
      rec_plots[u] = 0;
      rec_firstx[u] = -1;
      rec_firsty[u] = -1;
      rec_lastx[u] = -1;
      rec_lasty[u] = -1;
      rec_done_t[u] = 0;
      for (int d = 0; d < 4; d++) rec_ids[u][d] = -1;
    end
    rec_abort_done = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clock);
    start = 1'b1;
    score = 14'(sc);
    x_origin = 8'(xo);
    y_origin = 7'(yo);
    @(negedge clock);
    start = 1'b0;
    score = 14'($urandom);
    x_origin = 8'($urandom);
    y_origin = 7'($urandom);
    t = 1;
    while (t <= 2100) begin
      for (int u = 0; u < 2; u++) begin
        if (plotv[u]) begin
          rec_plots[u]++;
          if (rec_firstx[u] < 0) begin
            rec_firstx[u] = int'(xv[u]);
            rec_firsty[u] = int'(yv[u]);
          end
          rec_lastx[u] = int'(xv[u]);
          rec_lasty[u] = int'(yv[u]);
        end
        if (donev[u] && rec_done_t[u] == 0) rec_done_t[u] = t;
        if (t >= 15 && t <= 2062 && (t - 15) % 512 == 0) rec_ids[u][(t - 15) / 512] = int'(idv[u]);
      end
      if (abort_at > 0 && rec_plots[0] == abort_at) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("plot after abort", 0, 32'(plotv[0]), 32'd0);
        checkOutput("busy after abort", 0, 32'(busyv[0]), 32'd0);
        repeat (30) begin
          @(negedge clock);
          if (donev[0] || donev[1]) rec_abort_done = 1'b1;
        end
        return;
      end
      if (t == ignore_at) begin
        start = 1'b1;
        score = 14'($urandom);
      end else if (t == ignore_at + 1) begin
        start = 1'b0;
      end
      if (t == 2065) break;
      @(negedge clock);
      t++;
    end
    start = 1'b0;
  endtask

  task automatic checkIds(input string name, input int u, input int a, input int b, input int c, input int d);
    checkOutput({name, " id0"}, u, 32'(rec_ids[u][0]), 32'(a));
    checkOutput({name, " id1"}, u, 32'(rec_ids[u][1]), 32'(b));
    checkOutput({name, " id2"}, u, 32'(rec_ids[u][2]), 32'(c));
    checkOutput({name, " id3"}, u, 32'(rec_ids[u][3]), 32'(d));
  endtask

  task automatic checkRun(input string name);
    for (int u = 0; u < 2; u++) begin
      checkOutput({name, " plots"}, u, 32'(rec_plots[u]), 32'd2048);
      checkOutput({name, " done time"}, u, 32'(rec_done_t[u]), 32'd2064);
    end
  endtask

  // Directed scenarios with literal expectations, then randomized runs.
  initial begin
    reset = 1'b1;
    start = 1'b0;
    score = '0;
    x_origin = '0;
    y_origin = '0;
    repeat (3) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      checkOutput("reset id", u, 32'(idv[u]), 32'd0);
      checkOutput("reset i", u, 32'(iv[u]), 32'd0);
      checkOutput("reset j", u, 32'(jv[u]), 32'd0);
      checkOutput("reset x", u, 32'(xv[u]), 32'd0);
      checkOutput("reset y", u, 32'(yv[u]), 32'd0);
      checkOutput("reset colour", u, 32'(cv[u]), 32'd0);
      checkOutput("reset plot", u, 32'(plotv[u]), 32'd0);
      checkOutput("reset busy", u, 32'(busyv[u]), 32'd0);
      checkOutput("reset done", u, 32'(donev[u]), 32'd0);
    end
    reset = 1'b0;
    chk_en = 1'b1;

    $display("[TB] score 0 at (10,20)");
    applyStimulus(0, 10, 20, 0, 0);
    checkRun("zero");
    checkIds("zero", 0, 0, 0, 0, 0);
    checkIds("zero", 1, 10, 10, 10, 0);
    checkOutput("zero first x", 0, 32'(rec_firstx[0]), 32'd10);
    checkOutput("zero first y", 0, 32'(rec_firsty[0]), 32'd20);
    checkOutput("zero last x", 0, 32'(rec_lastx[0]), 32'd73);
    checkOutput("zero last y", 0, 32'(rec_lasty[0]), 32'd51);

    $display("[TB] score 1234");
    applyStimulus(1234, 30, 40, 0, 0);
    checkRun("1234");
    checkIds("1234", 0, 1, 2, 3, 4);
    checkIds("1234", 1, 1, 2, 3, 4);

    $display("[TB] score 12000 saturates");
    applyStimulus(12000, 0, 0, 0, 0);
    checkIds("sat", 0, 9, 9, 9, 9);
    checkIds("sat", 1, 9, 9, 9, 9);

    $display("[TB] leading zero blanking");
    applyStimulus(7, 100, 10, 0, 0);
    checkIds("seven", 0, 0, 0, 0, 7);
    checkIds("seven", 1, 10, 10, 10, 7);
    applyStimulus(1000, 100, 10, 0, 0);
    checkIds("thousand", 1, 1, 0, 0, 0);

    $display("[TB] start during draw is ignored");
    applyStimulus(4321, 0, 0, 500, 0);
    checkRun("ignore");
    checkIds("ignore", 0, 4, 3, 2, 1);

    $display("[TB] reset at plot 700");
    applyStimulus(5555, 50, 60, 0, 700);
    checkOutput("abort no done", 0, 32'(rec_abort_done), 32'd0);
    applyStimulus(86, 5, 5, 0, 0);
    checkRun("after abort");
    checkIds("after abort", 1, 10, 10, 8, 6);

    $display("[TB] origin wrap");
    applyStimulus(9876, 240, 100, 0, 0);
    checkOutput("wrap last x", 0, 32'(rec_lastx[0]), 32'd47);
    checkOutput("wrap last y", 0, 32'(rec_lasty[0]), 32'd3);

    $display("[TB] randomized runs");
    for (int n = 0; n < 4; n++) begin
      applyStimulus(int'($urandom_range(0, 16383)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 127)), 0, 0);
      checkRun("random");
    end

    repeat (3) @(negedge clock);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
